// File: rtl/sys_defs.sv
// Shared system definitions for the processor-to-memory bus: command encoding,
// tag space, block width and the arbiter's state/owner types.
package sys_defs;

    localparam int NUM_MEM_TAGS         = 16;
    localparam int DATA_SIZE            = 64;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        ARB_FREE   = 2'h0,
        ARB_LOCK_D = 2'h1,
        ARB_LOCK_I = 2'h2
    } ARB_STATE;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } ARB_OWNER;

endpackage

// File: rtl/mem_bus_arbiter_tag_table.sv
// Outstanding-load ownership table: one {valid, owner} entry per memory tag,
// steering each returned tag to the requester that issued the load.
module mem_tag_table
    import sys_defs::*;
#(
    parameter int NUM_TAGS = NUM_MEM_TAGS
)(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_setEn,
    input  logic [$clog2(NUM_TAGS)-1:0] i_setTag,
    input  ARB_OWNER                    i_setOwner,
    input  logic [$clog2(NUM_TAGS)-1:0] i_retTag,
    output logic [$clog2(NUM_TAGS)-1:0] o_dTag,
    output logic [$clog2(NUM_TAGS)-1:0] o_iTag,
    output logic                        o_tagErr
);

    logic     r_valid [NUM_TAGS];
    ARB_OWNER r_owner [NUM_TAGS];
    logic     r_tagErr;
    logic     w_retHit;
    logic     w_retMiss;

    assign w_retHit  = (i_retTag != '0) &&  r_valid[i_retTag];
    assign w_retMiss = (i_retTag != '0) && !r_valid[i_retTag];
    assign o_tagErr  = r_tagErr;

    always_comb begin
        o_dTag = '0;
        o_iTag = '0;
        if (!reset && w_retHit) begin
            if (r_owner[i_retTag] == OWN_I) begin
                o_iTag = i_retTag;
            end else begin
                o_dTag = i_retTag;
            end
        end
    end

    // The set is written after the clear so a tag returned and re-issued in the
    // same cycle stays valid under its new owner.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_TAGS; k++) begin
                r_valid[k] <= 1'b0;
                r_owner[k] <= OWN_D;
            end
            r_tagErr <= 1'b0;
        end else begin
            if (w_retHit) begin
                r_valid[i_retTag] <= 1'b0;
            end
            if (w_retMiss) begin
                r_tagErr <= 1'b1;
            end
            if (i_setEn) begin
                r_valid[i_setTag] <= 1'b1;
                r_owner[i_setTag] <= i_setOwner;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single memory bus between dcache and icache: dcache priority
// with an icache starvation guard, grant held until memory accepts.
module mem_bus_arbiter
    import sys_defs::*;
#(
    parameter int NUM_TAGS     = NUM_MEM_TAGS,
    parameter int DATA_W       = DATA_SIZE,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
)(
    input  logic                        clock,
    input  logic                        reset,
    input  BUS_COMMAND                  d_command,
    input  logic [31:0]                 d_addr,
    input  logic [DATA_W-1:0]           d_data,
    input  BUS_COMMAND                  i_command,
    input  logic [31:0]                 i_addr,
    output logic [$clog2(NUM_TAGS)-1:0] d_response,
    output logic [$clog2(NUM_TAGS)-1:0] i_response,
    output logic [$clog2(NUM_TAGS)-1:0] d_tag,
    output logic [$clog2(NUM_TAGS)-1:0] i_tag,
    output logic [DATA_W-1:0]           d_mem_data,
    output logic [DATA_W-1:0]           i_mem_data,
    output logic                        d_grant,
    output logic                        i_grant,
    output BUS_COMMAND                  proc2mem_command,
    output logic [31:0]                 proc2mem_addr,
    output logic [DATA_W-1:0]           proc2mem_data,
    input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_response,
    input  logic [$clog2(NUM_TAGS)-1:0] mem2proc_tag,
    input  logic [DATA_W-1:0]           mem2proc_data,
    output logic                        tag_err
);

    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    ARB_STATE         r_state;
    ARB_STATE         w_nextState;
    logic             w_dWin;
    logic             w_iWin;
    logic             w_accepted;
    logic             w_setEn;
    ARB_OWNER         w_setOwner;
    logic [CNT_W-1:0] r_starveCnt;
    logic [CNT_W-1:0] w_starveNext;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ARB_FREE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A locked requester that drops its command forfeits the cycle rather than
    // handing it to the other side.
    always_comb begin
        w_dWin = 1'b0;
        w_iWin = 1'b0;
        if (!reset) begin
            case (r_state)
                ARB_LOCK_D: w_dWin = (d_command != BUS_NONE);
                ARB_LOCK_I: w_iWin = (i_command != BUS_NONE);
                default: begin
                    if (i_command != BUS_NONE && r_starveCnt == STARVE_MAX) begin
                        w_iWin = 1'b1;
                    end else if (d_command != BUS_NONE) begin
                        w_dWin = 1'b1;
                    end else if (i_command != BUS_NONE) begin
                        w_iWin = 1'b1;
                    end
                end
            endcase
        end
        w_accepted  = (w_dWin || w_iWin) && (mem2proc_response != '0);
        w_nextState = ARB_FREE;
        if (w_dWin && !w_accepted) begin
            w_nextState = ARB_LOCK_D;
        end else if (w_iWin && !w_accepted) begin
            w_nextState = ARB_LOCK_I;
        end
    end

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (w_dWin) begin
            proc2mem_command = d_command;
            proc2mem_addr    = d_addr;
            proc2mem_data    = d_data;
        end else if (w_iWin) begin
            proc2mem_command = i_command;
            proc2mem_addr    = i_addr;
        end
    end

    assign d_grant    = w_dWin;
    assign i_grant    = w_iWin;
    assign d_response = w_dWin ? mem2proc_response : '0;
    assign i_response = w_iWin ? mem2proc_response : '0;
    assign d_mem_data = mem2proc_data;
    assign i_mem_data = mem2proc_data;

    // A rejected icache winner neither gains nor loses credit while it retries.
    always_comb begin
        w_starveNext = r_starveCnt;
        if (i_command == BUS_NONE || (w_iWin && w_accepted)) begin
            w_starveNext = '0;
        end else if (!w_iWin && r_starveCnt != STARVE_MAX) begin
            w_starveNext = r_starveCnt + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_starveCnt <= '0;
        end else begin
            r_starveCnt <= w_starveNext;
        end
    end

    assign w_setEn    = w_accepted && (proc2mem_command == BUS_LOAD);
    assign w_setOwner = w_iWin ? OWN_I : OWN_D;

    mem_tag_table #(
        .NUM_TAGS (NUM_TAGS)
    ) tagTable (
        .clock      (clock),
        .reset      (reset),
        .i_setEn    (w_setEn),
        .i_setTag   (mem2proc_response),
        .i_setOwner (w_setOwner),
        .i_retTag   (mem2proc_tag),
        .o_dTag     (d_tag),
        .o_iTag     (i_tag),
        .o_tagErr   (tag_err)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a behavioural ownership/priority model.
module tb_mem_bus_arbiter;
    import sys_defs::*;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    BUS_COMMAND  d_command;
    logic [31:0] d_addr;
    logic [63:0] d_data;
    BUS_COMMAND  i_command;
    logic [31:0] i_addr;
    logic [3:0]  d_response;
    logic [3:0]  i_response;
    logic [3:0]  d_tag;
    logic [3:0]  i_tag;
    logic [63:0] d_mem_data;
    logic [63:0] i_mem_data;
    logic        d_grant;
    logic        i_grant;
    BUS_COMMAND  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [3:0]  mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic        tag_err;

    always #5 clock = ~clock;

    mem_bus_arbiter #(
        .NUM_TAGS     (16),
        .DATA_W       (64),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .d_command         (d_command),
        .d_addr            (d_addr),
        .d_data            (d_data),
        .i_command         (i_command),
        .i_addr            (i_addr),
        .d_response        (d_response),
        .i_response        (i_response),
        .d_tag             (d_tag),
        .i_tag             (i_tag),
        .d_mem_data        (d_mem_data),
        .i_mem_data        (i_mem_data),
        .d_grant           (d_grant),
        .i_grant           (i_grant),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_tag      (mem2proc_tag),
        .mem2proc_data     (mem2proc_data),
        .tag_err           (tag_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: lock holder (-1 none, 0 dcache, 1 icache), denied-cycle
    // count for icache, per-tag owner (-1 free) and the sticky error flag.
    int         mLock = -1;
    int         mStarve = 0;
    int         mOwner [16];
    bit         mErr = 1'b0;
    logic [3:0] lastDResp;
    logic [3:0] lastIResp;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input BUS_COMMAND dc, input logic [31:0] da,
                                 input logic [63:0] dd, input BUS_COMMAND ic, input logic [31:0] ia,
                                 input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata);
        int          w;
        bit          acc;
        bit          dReq;
        bit          iReq;
        BUS_COMMAND  eCmd;
        logic [31:0] eAddr;
        logic [63:0] eData;
        logic [3:0]  eDTag;
        logic [3:0]  eITag;
        @(negedge clock);
        reset             = rst;
        d_command         = dc;
        d_addr            = da;
        d_data            = dd;
        i_command         = ic;
        i_addr            = ia;
        mem2proc_response = resp;
        mem2proc_tag      = rtag;
        mem2proc_data     = rdata;
        #2;
        dReq = (dc != BUS_NONE);
        iReq = (ic != BUS_NONE);
        w = -1;
        if (!rst) begin
            if (mLock == 0) w = dReq ? 0 : -1;
            else if (mLock == 1) w = iReq ? 1 : -1;
            else if (iReq && mStarve >= LIMIT) w = 1;
            else if (dReq) w = 0;
            else if (iReq) w = 1;
        end
        eCmd  = BUS_NONE;
        eAddr = '0;
        eData = '0;
        if (w == 0) begin
            eCmd  = dc;
            eAddr = da;
            eData = dd;
        end else if (w == 1) begin
            eCmd  = ic;
            eAddr = ia;
        end
        acc   = (w >= 0) && (resp != 4'd0);
        eDTag = 4'd0;
        eITag = 4'd0;
        if (!rst && rtag != 4'd0) begin
            if (mOwner[rtag] == 0) eDTag = rtag;
            else if (mOwner[rtag] == 1) eITag = rtag;
        end
        lastDResp = (w == 0) ? resp : 4'd0;
        lastIResp = (w == 1) ? resp : 4'd0;
        checkOutput("d_grant",   64'(d_grant), 64'(w == 0));
        checkOutput("i_grant",   64'(i_grant), 64'(w == 1));
        checkOutput("d_response", 64'(d_response), 64'(lastDResp));
        checkOutput("i_response", 64'(i_response), 64'(lastIResp));
        checkOutput("p2m_cmd",   64'(proc2mem_command), 64'(eCmd));
        checkOutput("p2m_addr",  64'(proc2mem_addr), 64'(eAddr));
        checkOutput("p2m_data",  proc2mem_data, eData);
        checkOutput("d_tag",     64'(d_tag), 64'(eDTag));
        checkOutput("i_tag",     64'(i_tag), 64'(eITag));
        checkOutput("d_mem_data", d_mem_data, rdata);
        checkOutput("i_mem_data", i_mem_data, rdata);
        checkOutput("tag_err",   64'(tag_err), 64'(mErr));
        @(posedge clock);
        if (rst) begin
            mLock   = -1;
            mStarve = 0;
            foreach (mOwner[k]) mOwner[k] = -1;
            mErr    = 1'b0;
        end else begin
            mLock = (w >= 0 && resp == 4'd0) ? w : -1;
            if (!iReq || (w == 1 && acc)) mStarve = 0;
            else if (w != 1 && mStarve < LIMIT) mStarve++;
            if (rtag != 4'd0) begin
                if (mOwner[rtag] < 0) mErr = 1'b1;
                else mOwner[rtag] = -1;
            end
            if (acc && eCmd == BUS_LOAD) mOwner[resp] = w;
        end
    endtask

    initial begin
        bit          iOn;
        bit          dAct;
        bit          iAct;
        bit          rst;
        BUS_COMMAND  dC;
        logic [31:0] dA;
        logic [63:0] dD;
        logic [31:0] iA;
        logic [3:0]  resp;
        logic [3:0]  rtag;
        int          owned [$];

        foreach (mOwner[k]) mOwner[k] = -1;
        reset             = 1'b1;
        d_command         = BUS_NONE;
        d_addr            = '0;
        d_data            = '0;
        i_command         = BUS_NONE;
        i_addr            = '0;
        mem2proc_response = '0;
        mem2proc_tag      = '0;
        mem2proc_data     = '0;
        repeat (2) @(posedge clock);

        applyStimulus(1, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 64'h0);
        applyStimulus(1, BUS_LOAD, 32'h10, 64'h1, BUS_LOAD, 32'h20, 4'd3, 4'd3, 64'hDEAD);

        applyStimulus(0, BUS_LOAD, 32'h1000, 0, BUS_NONE, 0, 4'd3, 0, 64'h11);
        applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd3, 64'hABCD_0003);

        applyStimulus(0, BUS_LOAD, 32'h2000, 0, BUS_LOAD, 32'h3000, 4'd0, 0, 0);
        applyStimulus(0, BUS_LOAD, 32'h2000, 0, BUS_LOAD, 32'h3000, 4'd0, 0, 0);
        applyStimulus(0, BUS_LOAD, 32'h2000, 0, BUS_LOAD, 32'h3000, 4'd5, 0, 0);
        applyStimulus(0, BUS_NONE, 0, 0, BUS_LOAD, 32'h3000, 4'd6, 0, 0);
        applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd5, 64'h5);
        applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd6, 64'h6);

        iOn = 1'b1;
        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, BUS_STORE, 32'h5000 + 32'(k), 64'(k) + 64'h77, iOn ? BUS_LOAD : BUS_NONE,
                          32'h4000, 4'd9, 0, 0);
            if (lastIResp != 4'd0) iOn = 1'b0;
        end
        applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd9, 64'h9);

        applyStimulus(0, BUS_STORE, 32'h6000, 64'h1234, BUS_NONE, 0, 4'd7, 0, 0);
        applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd7, 64'h7);
        applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);

        applyStimulus(1, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
        applyStimulus(0, BUS_NONE, 0, 0, BUS_LOAD, 32'h7000, 4'd2, 0, 0);
        applyStimulus(0, BUS_LOAD, 32'h7100, 0, BUS_NONE, 0, 4'd2, 4'd2, 64'h22);
        applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd2, 64'h23);

        applyStimulus(0, BUS_LOAD, 32'h8000, 0, BUS_NONE, 0, 4'd1, 0, 0);
        applyStimulus(0, BUS_NONE, 0, 0, BUS_LOAD, 32'h8100, 4'd4, 0, 0);
        applyStimulus(1, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
        applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd4, 64'h44);
        applyStimulus(0, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
        applyStimulus(1, BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);

        dAct = 1'b0;
        iAct = 1'b0;
        dC   = BUS_NONE;
        dA   = '0;
        dD   = '0;
        iA   = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!dAct && $urandom_range(0, 2) != 0) begin
                dAct = 1'b1;
                dC   = ($urandom_range(0, 1) == 1) ? BUS_LOAD : BUS_STORE;
                dA   = $urandom;
                dD   = {$urandom, $urandom};
            end
            if (!iAct && $urandom_range(0, 2) != 0) begin
                iAct = 1'b1;
                iA   = $urandom;
            end
            rst  = ($urandom_range(0, 99) == 0);
            resp = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(1, 15));
            owned.delete();
            foreach (mOwner[k]) if (k != 0 && mOwner[k] >= 0) owned.push_back(k);
            if (owned.size() > 0 && $urandom_range(0, 9) < 6) begin
                rtag = 4'(owned[$urandom_range(0, owned.size() - 1)]);
            end else if ($urandom_range(0, 3) == 0) begin
                rtag = 4'($urandom_range(1, 15));
            end else begin
                rtag = 4'd0;
            end
            applyStimulus(rst, dAct ? dC : BUS_NONE, dAct ? dA : 32'h0, dAct ? dD : 64'h0,
                          iAct ? BUS_LOAD : BUS_NONE, iAct ? iA : 32'h0, resp, rtag,
                          {$urandom, $urandom});
            if (lastDResp != 4'd0) dAct = 1'b0;
            if (lastIResp != 4'd0) iAct = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
